// File: rtl/fpga_lib_pkg.sv
// fpga_lib_pkg: shared types and constants for the fpga_lib debounce blocks.
//   db_state_t : debounce FSM state encoding
//   DB_CNT_W   : width of the consecutive-sample debounce counter
//   width_for  : bits needed to hold a value (minimum 1); used to size timers
package fpga_lib_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHK_HI    = 2'd1,
      STABLE_HI = 2'd2,
      CHK_LO    = 2'd3
   } db_state_t;

   localparam int unsigned DB_CNT_W = 16;

   function automatic int unsigned width_for(input int unsigned value);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((value >> i) != 0) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/long_press_timer.sv
// long_press_timer: saturating one-shot hold timer.
// Counts cycles while run is high; fire pulses for one cycle when the count
// reaches HOLD_CYCLES-1, then the timer saturates so it fires once per run
// period. Dropping run clears the timer.
// Ports:
//   sys_clk : clock
//   rst_n   : synchronous active-low reset
//   run     : hold condition; timer is held at 0 while low
//   fire    : one-cycle registered pulse
module long_press_timer
   import fpga_lib_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 50000
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic run,
   output logic fire
);

   localparam int unsigned TW = width_for(HOLD_CYCLES);
   localparam logic [TW-1:0] LAST = TW'(HOLD_CYCLES - 1);
   // One past LAST marks "already fired" so the pulse cannot repeat.
   localparam logic [TW-1:0] DONE = TW'(HOLD_CYCLES);

   logic [TW-1:0] timer;

   always_ff @(posedge sys_clk) begin
      if (!rst_n || !run) begin
         timer <= '0;
         fire  <= 1'b0;
      end else if (timer == LAST) begin
         timer <= DONE;
         fire  <= 1'b1;
      end else begin
         fire <= 1'b0;
         if (timer != DONE) timer <= timer + TW'(1);
      end
   end

endmodule

// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect: glitch filter and edge detector for an already
// synchronized level in the sys_clk domain.
// i_level must flip for DEBOUNCE_CYCLES consecutive samples before o_level
// follows; o_rise/o_fall pulse for one cycle together with the new level,
// and o_edge_cnt counts rises (wrapping).
// Optional: define LONG_PRESS_EN to enable o_long, a one-shot pulse after
// o_level has been high for LONG_CYCLES cycles; otherwise o_long is 0.
// Ports:
//   sys_clk    : clock
//   rst_n      : synchronous active-low reset
//   i_level    : synchronized input level
//   i_cnt_clr  : synchronous clear of o_edge_cnt
//   o_level    : debounced level
//   o_rise     : one-cycle pulse on o_level 0->1
//   o_fall     : one-cycle pulse on o_level 1->0
//   o_edge_cnt : wrapping count of o_rise events
//   o_long     : one-cycle long-press pulse
module debounce_edge_detect
   import fpga_lib_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter logic        RESET_LEVEL     = 1'b0,
   parameter int unsigned EDGE_CNT_W      = 8,
   parameter int unsigned LONG_CYCLES     = 50000
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  i_level,
   input  logic                  i_cnt_clr,
   output logic                  o_level,
   output logic                  o_rise,
   output logic                  o_fall,
   output logic [EDGE_CNT_W-1:0] o_edge_cnt,
   output logic                  o_long
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || LONG_CYCLES < 1) begin : g_bad_params
      $error("debounce_edge_detect: parameter out of range");
   end

   localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam db_state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

   db_state_t             state, state_nx;
   logic [DB_CNT_W-1:0]   cnt, cnt_nx;
   logic                  rise_nx, fall_nx, level_nx;
   logic [EDGE_CNT_W-1:0] edge_nx;

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state      <= RESET_STATE;
         cnt        <= '0;
         o_level    <= RESET_LEVEL;
         o_rise     <= 1'b0;
         o_fall     <= 1'b0;
         o_edge_cnt <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         o_level    <= level_nx;
         o_rise     <= rise_nx;
         o_fall     <= fall_nx;
         o_edge_cnt <= edge_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      unique case (state)
         STABLE_LO: begin
            if (i_level) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nx = STABLE_HI;
                  rise_nx  = 1'b1;
               end else begin
                  state_nx = CHK_HI;
                  cnt_nx   = DB_CNT_W'(1);
               end
            end
         end
         CHK_HI: begin
            if (!i_level) begin
               state_nx = STABLE_LO;
            end else if (cnt == LAST) begin
               state_nx = STABLE_HI;
               rise_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + DB_CNT_W'(1);
            end
         end
         STABLE_HI: begin
            if (!i_level) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nx = STABLE_LO;
                  fall_nx  = 1'b1;
               end else begin
                  state_nx = CHK_LO;
                  cnt_nx   = DB_CNT_W'(1);
               end
            end
         end
         CHK_LO: begin
            if (i_level) begin
               state_nx = STABLE_HI;
            end else if (cnt == LAST) begin
               state_nx = STABLE_LO;
               fall_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + DB_CNT_W'(1);
            end
         end
         default: state_nx = RESET_STATE;
      endcase

      // The stable level is a function of state: CHK_LO still reports high.
      level_nx = (state_nx == STABLE_HI) || (state_nx == CHK_LO);

      // Clear takes effect first so a coincident rise lands on 1.
      edge_nx = i_cnt_clr ? '0 : o_edge_cnt;
      if (rise_nx) edge_nx = edge_nx + EDGE_CNT_W'(1);
   end

`ifdef LONG_PRESS_EN
   long_press_timer #(
      .HOLD_CYCLES(LONG_CYCLES)
   ) u_long_press_timer (
      .sys_clk(sys_clk),
      .rst_n  (rst_n),
      .run    (state == STABLE_HI),
      .fire   (o_long)
   );
`else
   assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
module tb_debounce_edge_detect;

   localparam int unsigned DB = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned LC = 10;

   logic         sys_clk = 1'b0;
   logic         rst_n;
   logic         i_level;
   logic         i_cnt_clr;
   logic         o_level;
   logic         o_rise;
   logic         o_fall;
   logic [W-1:0] o_edge_cnt;
   logic         o_long;

   int checks = 0;
   int errors = 0;
   bit long_on;

   debounce_edge_detect #(
      .DEBOUNCE_CYCLES(DB),
      .RESET_LEVEL    (1'b0),
      .EDGE_CNT_W     (W),
      .LONG_CYCLES    (LC)
   ) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .i_level   (i_level),
      .i_cnt_clr (i_cnt_clr),
      .o_level   (o_level),
      .o_rise    (o_rise),
      .o_fall    (o_fall),
      .o_edge_cnt(o_edge_cnt),
      .o_long    (o_long)
   );

   always #5 sys_clk = ~sys_clk;

   // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic lvl, input logic r,
                             input logic f, input logic [W-1:0] ec);
      check({tag, ".level"}, 32'(o_level), 32'(lvl));
      check({tag, ".rise"},  32'(o_rise),  32'(r));
      check({tag, ".fall"},  32'(o_fall),  32'(f));
      check({tag, ".cnt"},   32'(o_edge_cnt), 32'(ec));
   endtask

   // Clean rise then clean fall from STABLE_LO, no checks inside.
   task automatic pulse_high;
      i_level = 1'b1; tick(DB);
      i_level = 1'b0; tick(DB);
   endtask

   initial begin
`ifdef LONG_PRESS_EN
      long_on = 1'b1;
`else
      long_on = 1'b0;
`endif
      rst_n = 1'b0; i_level = 1'b1; i_cnt_clr = 1'b0;

      // 1. reset with input high, then first rise after DB samples
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check_outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);
         check("reset.long", 32'(o_long), 32'd0);
      end
      rst_n = 1'b1;
      for (int i = 1; i < DB; i++) begin
         tick(1);
         check_outs("rise.wait", 1'b0, 1'b0, 1'b0, 8'd0);
      end
      tick(1);
      check_outs("rise.edge", 1'b1, 1'b1, 1'b0, 8'd1);
      tick(1);
      check_outs("rise.after", 1'b1, 1'b0, 1'b0, 8'd1);

      // 3. fall
      i_level = 1'b0;
      for (int i = 1; i < DB; i++) begin
         tick(1);
         check_outs("fall.wait", 1'b1, 1'b0, 1'b0, 8'd1);
      end
      tick(1);
      check_outs("fall.edge", 1'b0, 1'b0, 1'b1, 8'd1);
      tick(1);
      check_outs("fall.after", 1'b0, 1'b0, 1'b0, 8'd1);

      // 2. glitch of DB-1 samples is rejected, and the count restarts
      i_level = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check_outs("glitch.hi", 1'b0, 1'b0, 1'b0, 8'd1);
      end
      i_level = 1'b0;
      tick(2);
      check_outs("glitch.lo", 1'b0, 1'b0, 1'b0, 8'd1);
      i_level = 1'b1;
      tick(DB - 1);
      check_outs("glitch.restart", 1'b0, 1'b0, 1'b0, 8'd1);
      i_level = 1'b0;
      tick(2);

      // 4A. wrap: 254 more rises reach 255, one more wraps to 0
      for (int i = 0; i < 254; i++) pulse_high();
      check("wrap.255", 32'(o_edge_cnt), 32'd255);
      i_level = 1'b1; tick(DB);
      check_outs("wrap.0", 1'b1, 1'b1, 1'b0, 8'd0);
      i_level = 1'b0; tick(DB);
      pulse_high();
      pulse_high();
      check("wrap.2", 32'(o_edge_cnt), 32'd2);

      // clear alone
      i_cnt_clr = 1'b1; tick(1); i_cnt_clr = 1'b0;
      check("clr.alone", 32'(o_edge_cnt), 32'd0);
      pulse_high();
      pulse_high();
      check("clr.reload", 32'(o_edge_cnt), 32'd2);

      // 4B. clear coincident with rise-flip
      i_level = 1'b1; tick(DB - 1);
      i_cnt_clr = 1'b1; tick(1); i_cnt_clr = 1'b0;
      check_outs("clr.rise", 1'b1, 1'b1, 1'b0, 8'd1);
      i_level = 1'b0; tick(DB);
      check_outs("clr.fall", 1'b0, 1'b0, 1'b1, 8'd1);
      tick(1);

      // 5. reset while counter=2 in CHK_HI
      i_level = 1'b1; tick(2);
      rst_n = 1'b0; tick(1);
      check_outs("midrst", 1'b0, 1'b0, 1'b0, 8'd0);
      rst_n = 1'b1;
      for (int i = 1; i < DB; i++) begin
         tick(1);
         check_outs("midrst.wait", 1'b0, 1'b0, 1'b0, 8'd0);
      end
      tick(1);
      check_outs("midrst.rise", 1'b1, 1'b1, 1'b0, 8'd1);

      // 6A. hold high 25 cycles after rise: one o_long, 10 cycles in
      for (int k = 1; k <= 25; k++) begin
         tick(1);
         check($sformatf("long.hold%0d", k), 32'(o_long), 32'(long_on && (k == LC)));
      end
      check("long.level", 32'(o_level), 32'd1);
      i_level = 1'b0;
      for (int k = 0; k < DB + 2; k++) begin
         tick(1);
         check("long.falling", 32'(o_long), 32'd0);
      end

      // 6B. release after 5 cycles high: no o_long
      i_level = 1'b1; tick(DB);
      check_outs("short.rise", 1'b1, 1'b1, 1'b0, 8'd2);
      tick(5);
      i_level = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         check("short.nolong", 32'(o_long), 32'd0);
      end
      check_outs("short.end", 1'b0, 1'b0, 1'b0, 8'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
